// File: rtl/data_ram_responder.sv
// data_ram_responder: memory-side responder for the load/store unit.
// Accepts one byte/half/word request, waits a fixed LATENCY, then performs the
// access on the internal data array and returns a single-cycle response.
// Lane steering, store masking and load sign/zero extension all happen here.
module data_ram_responder #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_bhw_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Misaligned half/word or the reserved size code.
    function automatic logic access_err(input logic [2:0] bhw, input logic [1:0] lane);
        logic err;
        case (bhw[1:0])
            2'b00:   err = 1'b0;
            2'b01:   err = lane[0];
            2'b10:   err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Byte-lane enables for a store of the given size at the given lane.
    function automatic logic [3:0] store_be(input logic [2:0] bhw, input logic [1:0] lane);
        logic [3:0] be;
        case (bhw[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low bits of the store data across every lane it may land in.
    function automatic logic [31:0] store_lanes(input logic [2:0] bhw, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (bhw[1:0])
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            2'b10:   lanes = wdata;
            default: lanes = 32'h0000_0000;
        endcase
        return lanes;
    endfunction

    // Pick the addressed byte/half out of the word, right-justify and extend.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] bhw,
                                                input logic [1:0] lane);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (bhw[1:0])
            2'b00:   res = bhw[2] ? {24'h00_0000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = bhw[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               we_q;
    logic [2:0]         bhw_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic               req_ready_s;
    logic               accept_s;
    logic               enter_resp_s;
    logic               op_we_s;
    logic [2:0]         op_bhw_s;
    logic [31:0]        op_addr_s;
    logic [31:0]        op_wdata_s;
    logic               op_err_s;
    logic [AW-1:0]      idx_s;
    logic [31:0]        rd_word_s;
    logic [3:0]         be_s;
    logic [31:0]        lanes_s;
    logic               mem_we_s;
    logic               unused_addr_s;

    assign req_ready_s = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign accept_s    = req_valid_i & req_ready_s;

    // With a single-cycle latency the access happens on the accept edge itself,
    // so the operands come straight from the request rather than the latches.
    assign op_we_s    = (LATENCY == 1) ? req_we_i    : we_q;
    assign op_bhw_s   = (LATENCY == 1) ? req_bhw_i   : bhw_q;
    assign op_addr_s  = (LATENCY == 1) ? req_addr_i  : addr_q;
    assign op_wdata_s = (LATENCY == 1) ? req_wdata_i : wdata_q;

    assign idx_s         = op_addr_s[AW+1:2];
    assign unused_addr_s = &{1'b0, op_addr_s[31:AW+2]};
    assign op_err_s      = access_err(op_bhw_s, op_addr_s[1:0]);
    assign rd_word_s     = mem_q[idx_s];
    assign be_s          = store_be(op_bhw_s, op_addr_s[1:0]);
    assign lanes_s       = store_lanes(op_bhw_s, op_wdata_s);
    assign enter_resp_s  = (state_d == ST_RESP);
    // A reset arriving mid-flight must drop the pending store.
    assign mem_we_s      = enter_resp_s & ~rst_i & op_we_s & ~op_err_s;

    // Next-state and countdown logic for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
                cnt_d = cnt_q - CW'(1);
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CW'(0);
            end
        endcase
    end

    // Response values computed for the edge that enters RESP; zero otherwise.
    always_comb begin
        resp_valid_d = enter_resp_s;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        if (enter_resp_s) begin
            resp_err_d = op_err_s;
            if (op_err_s || op_we_s) begin
                resp_rdata_d = 32'h0000_0000;
            end else begin
                resp_rdata_d = load_extend(rd_word_s, op_bhw_s, op_addr_s[1:0]);
            end
        end else begin
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'h0000_0000;
        end
    end

    // State, countdown and registered response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CW'(0);
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Capture the request fields on accept; they stay stable until the access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            bhw_q   <= 3'b000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
        end else if (accept_s) begin
            we_q    <= req_we_i;
            bhw_q   <= req_bhw_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
        end
    end

    // Byte-masked store into the array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= lanes_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready_o  = req_ready_s;
    assign busy_o       = (state_q != ST_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule
